// File: rtl/car_velocity_integrator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | car_velocity_integrator                                                  |
// | Turns the accelerator command into a clamped signed velocity and a       |
// | wrapping track position, updated once per physics tick.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module car_velocity_integrator #(
   parameter int TICK_DIV       = 833333,
   parameter int VMAX           = 15,
   parameter int VEL_W          = 6,
   parameter int FRICTION_TICKS = 4,
   parameter int POS_W          = 10
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [1:0]              accel,
   output logic signed [VEL_W-1:0] velocity,
   output logic [POS_W-1:0]        position,
   output logic                    tick,
   output logic [1:0]              dir
);

   localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int FRIC_W = (FRICTION_TICKS > 1) ? $clog2(FRICTION_TICKS) : 1;
   // Two guard bits so v+2 / v-2 can be clamped before narrowing.
   localparam int EXT_W  = VEL_W + 2;
   localparam int SUM_W  = ((POS_W > VEL_W) ? POS_W : VEL_W) + 1;

   localparam logic [DIV_W-1:0]         c_div_last  = DIV_W'(TICK_DIV - 1);
   localparam logic [FRIC_W-1:0]        c_fric_last = FRIC_W'(FRICTION_TICKS - 1);
   localparam logic signed [EXT_W-1:0]  c_zero      = EXT_W'(0);
   localparam logic signed [EXT_W-1:0]  c_one       = EXT_W'(1);
   localparam logic signed [EXT_W-1:0]  c_two       = EXT_W'(2);
   localparam logic signed [EXT_W-1:0]  c_vmax      = EXT_W'(VMAX);

   logic [1:0]              r_accel_m;
   logic [1:0]              r_accel_s;
   logic [DIV_W-1:0]        r_div;
   logic [FRIC_W-1:0]       r_fric;

   logic signed [EXT_W-1:0] w_v;
   logic signed [EXT_W-1:0] w_v_next;
   logic [FRIC_W-1:0]       w_fric_next;
   logic [1:0]              w_dir_next;
   logic [POS_W-1:0]        w_pos_next;

   always_comb begin
      w_v         = EXT_W'(velocity);
      w_v_next    = w_v;
      w_fric_next = r_fric;
      w_dir_next  = 2'b00;
      case (r_accel_s)
         2'b10: begin
            w_fric_next = '0;
            if (w_v < c_zero) begin
               w_v_next = w_v + c_two;
               if (w_v_next > c_zero) w_v_next = c_zero;
            end else begin
               w_v_next = w_v + c_one;
               if (w_v_next > c_vmax) w_v_next = c_vmax;
            end
         end
         2'b01: begin
            w_fric_next = '0;
            if (w_v > c_zero) begin
               w_v_next = w_v - c_two;
               if (w_v_next < c_zero) w_v_next = c_zero;
            end else begin
               w_v_next = w_v - c_one;
               if (w_v_next < -c_vmax) w_v_next = -c_vmax;
            end
         end
         default: begin
            if (w_v == c_zero) begin
               w_fric_next = '0;
            end else if (r_fric == c_fric_last) begin
               w_fric_next = '0;
               w_v_next    = (w_v > c_zero) ? (w_v - c_one) : (w_v + c_one);
            end else begin
               w_fric_next = r_fric + FRIC_W'(1);
            end
         end
      endcase
      if (w_v_next > c_zero)      w_dir_next = 2'b01;
      else if (w_v_next < c_zero) w_dir_next = 2'b10;
      // Position integrates the pre-update velocity; sign extension gives wrap both ways.
      w_pos_next = POS_W'(SUM_W'(position) + SUM_W'(velocity));
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_accel_m <= '0;
         r_accel_s <= '0;
         r_div     <= '0;
         r_fric    <= '0;
         velocity  <= '0;
         position  <= '0;
         tick      <= 1'b0;
         dir       <= 2'b00;
      end else begin
         r_accel_m <= accel;
         r_accel_s <= r_accel_m;
         if (r_div == c_div_last) begin
            r_div    <= '0;
            tick     <= 1'b1;
            r_fric   <= w_fric_next;
            velocity <= VEL_W'(w_v_next);
            position <= w_pos_next;
            dir      <= w_dir_next;
         end else begin
            r_div    <= r_div + DIV_W'(1);
            tick     <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
